// File: rtl/mux_arbiter.sv
// Round-robin arbiter that drives the select of an n-way mux.
// It holds a grant for up to max_burst back-to-back transfers before rotating.
module mux_arbiter #(
    parameter int unsigned switch_bits = 1,
    parameter int unsigned max_burst   = 1,
    localparam int unsigned n_cell     = 1 << switch_bits
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [n_cell-1:0]      req,
    output logic [n_cell-1:0]      ack,
    output logic [switch_bits-1:0] sel,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int unsigned CNT_W      = 8;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(max_burst - 1);

    typedef enum logic [0:0] {IDLE, GRANT} state_e;

    state_e                 state_q, state_d;
    logic [switch_bits-1:0] sel_q, sel_d;
    logic                   out_valid_q, out_valid_d;
    logic [switch_bits-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]       burst_cnt_q, burst_cnt_d;

    logic [switch_bits-1:0] next_ptr_c;
    logic [switch_bits-1:0] search_base_c;
    logic [switch_bits-1:0] win_c;
    logic                   win_found_c;

    assign next_ptr_c = sel_q + switch_bits'(1);

    // While granting, the only re-arbitration happens after rotation, so search from sel+1.
    assign search_base_c = (state_q == GRANT) ? next_ptr_c : ptr_q;

    // First requester at or after the search base, wrapping around.
    always_comb begin
        logic [switch_bits-1:0] idx;
        win_c       = '0;
        win_found_c = 1'b0;
        idx         = '0;
        for (int unsigned k = 0; k < n_cell; k++) begin
            idx = switch_bits'(32'(search_base_c) + k);
            if (!win_found_c && req[idx]) begin
                win_found_c = 1'b1;
                win_c       = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found_c) begin
                    sel_d       = win_c;
                    out_valid_d = 1'b1;
                    burst_cnt_d = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (out_ready) begin
                    // Counter never exceeds BURST_LAST, so inequality is the "< max_burst-1" test.
                    if (req[sel_q] && (burst_cnt_q != BURST_LAST)) begin
                        burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    end else begin
                        ptr_d       = next_ptr_c;
                        burst_cnt_d = '0;
                        if (win_found_c) begin
                            sel_d = win_c;
                        end else begin
                            out_valid_d = 1'b0;
                            state_d     = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Ack is a decode of the live handshake; suppressed while reset is asserted.
    always_comb begin
        ack = '0;
        if (rst_n && out_valid_q && out_ready) begin
            ack = n_cell'(1) << sel_q;
        end
    end

    assign sel       = sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: cycle-level reference model feeds a queue of expected
// outputs, and an independent monitor compares the DUT against it.
module tb_mux_arbiter;

    localparam int unsigned SB = 2;
    localparam int unsigned N  = 1 << SB;
    localparam int unsigned MB = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  ack;
    logic [SB-1:0] sel;
    logic          out_valid;
    logic          out_ready = 1'b0;

    mux_arbiter #(.switch_bits(SB), .max_burst(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ack       (ack),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          v;
        logic [SB-1:0] s;
        logic [N-1:0]  a;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Nearest requester going upward from p (modular distance), or -1.
    function automatic int pick(input logic [N-1:0] r, input int p);
        int best = -1;
        int bd   = N;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                int d = (i - p + N) % N;
                if (d < bd) begin
                    bd   = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    // Reference model: transaction rules evaluated once per cycle at the falling edge.
    initial begin
        bit m_valid = 0;
        int m_sel   = 0;
        int m_ptr   = 0;
        int m_done  = 0;
        @(posedge clk);
        forever begin
            exp_t e;
            int   w;
            @(negedge clk);
            e.v = m_valid;
            e.s = SB'(m_sel);
            e.a = (rst_n && m_valid && out_ready) ? N'(1 << m_sel) : '0;
            exp_q.push_back(e);
            if (!rst_n) begin
                m_valid = 0; m_sel = 0; m_ptr = 0; m_done = 0;
            end else if (!m_valid) begin
                w = pick(req, m_ptr);
                if (w >= 0) begin
                    m_valid = 1; m_sel = w; m_done = 0;
                end
            end else if (out_ready) begin
                if (req[m_sel] && (m_done + 1 < MB)) begin
                    m_done++;
                end else begin
                    m_ptr  = (m_sel + 1) % N;
                    m_done = 0;
                    w = pick(req, m_ptr);
                    if (w >= 0) m_sel = w;
                    else        m_valid = 0;
                end
            end
        end
    end

    // Monitor: samples DUT just after the falling edge and checks against the queue.
    initial begin
        @(posedge clk);
        forever begin
            exp_t e;
            @(negedge clk);
            #1;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL queue_empty: no expected entry at t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (out_valid !== e.v || (e.v && sel !== e.s) || ack !== e.a) begin
                    n_err++;
                    $display("FAIL outputs t=%0t: got valid=%b sel=%0d ack=%b, want valid=%b sel=%0d ack=%b",
                             $time, out_valid, sel, ack, e.v, e.s, e.a);
                end
            end
            n_vec++;
            if ($countones(ack) > 1 || (ack != '0 && !out_valid)) begin
                n_err++;
                $display("FAIL ack_onehot t=%0t: got ack=%b valid=%b, want at most one bit and only with valid",
                         $time, ack, out_valid);
            end
        end
    end

    task automatic drive(input logic [N-1:0] r, input logic rdy, input logic rs, input int n);
        for (int i = 0; i < n; i++) begin
            req       = r;
            out_ready = rdy;
            rst_n     = rs;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset with all requests pending, then round robin with bursts.
        drive(4'b1111, 1'b1, 1'b0, 2);
        drive(4'b1111, 1'b1, 1'b1, 14);
        drive(4'b0000, 1'b0, 1'b1, 2);
        // Stalled grant, then a single accept and the request drops.
        drive(4'b0100, 1'b0, 1'b1, 5);
        drive(4'b0100, 1'b1, 1'b1, 1);
        drive(4'b0000, 1'b1, 1'b1, 2);
        // Two requesters with burst limit.
        drive(4'b0011, 1'b1, 1'b1, 10);
        drive(4'b0000, 1'b1, 1'b1, 2);
        // Wrap and sparse requests, sole requester re-granted.
        drive(4'b1000, 1'b1, 1'b1, 1);
        drive(4'b1001, 1'b1, 1'b1, 4);
        drive(4'b1000, 1'b1, 1'b1, 5);
        drive(4'b0000, 1'b1, 1'b1, 2);
        // Reset during a stalled transfer.
        drive(4'b0010, 1'b0, 1'b1, 3);
        drive(4'b0010, 1'b0, 1'b0, 1);
        drive(4'b0000, 1'b1, 1'b1, 2);
        // Request withdrawn mid-grant; transfer still completes.
        drive(4'b0001, 1'b0, 1'b1, 2);
        drive(4'b0000, 1'b0, 1'b1, 2);
        drive(4'b0000, 1'b1, 1'b1, 2);
        // Random traffic including occasional resets.
        for (int i = 0; i < 2000; i++) begin
            drive(N'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) != 0), 1);
        end
        drive(4'b0000, 1'b0, 1'b1, 3);
        @(negedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: got %0d leftover entries, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
Name: mux_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the n-way mux in the proc datapath.
- Takes per-source request lines and registers the select index that drives the mux `q` input.
- Presents the muxed word to the consumer through a valid/ready handshake and returns a one-hot ack to the source whose word was taken.
- Burst limit allows a source to keep the grant for consecutive transfers before priority rotates.

Parameters:
- switch_bits, 1, width of the select; matches the mux `switch_bits`.
- n_cell, 1 << switch_bits, number of sources; derived, never overridden.
- max_burst, 1, max consecutive transfers granted to one source before rotation; legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- req  input  n_cell  per-source request; bit i = source i has a word on mux input i.
- ack  output  n_cell  one-hot; bit sel high in the cycle out_valid && out_ready.
- sel  output  switch_bits  registered select to the mux `q`.
- out_valid  output  1  muxed word on the mux output is valid.
- out_ready  input  1  consumer accepts the word this cycle.

Behaviour:
- Interface: one clock (clk); reset is synchronous, active-low (rst_n); sampled on the rising clk edge.
- Reset values: sel=0, out_valid=0, ptr=0, burst_cnt=0, state=IDLE.
- ack is combinationally forced to 0 while rst_n=0.
- Internal state:
  - ptr (switch_bits): priority pointer.
  - burst_cnt (8 bits): transfers already done by the current holder.
  - FSM with two states: IDLE, GRANT.
- Arbitration function: first i with req[i]=1, searching ptr, ptr+1, ..., n_cell-1, 0, ..., ptr-1 (mod n_cell).
- IDLE:
  - If req != 0: sel <= winner, out_valid <= 1, burst_cnt <= 0, go to GRANT.
  - Latency from req rising to out_valid is 1 cycle.
  - If req == 0, remain in IDLE.
- GRANT, out_ready=0:
  - Hold sel and out_valid stable.
  - ack = 0.
  - req changes are ignored.
- GRANT, out_ready=1:
  - ack = onehot(sel) in that cycle (combinational decode of the handshake).
  - If req[sel]=1 and burst_cnt < max_burst-1: keep sel, burst_cnt <= burst_cnt+1, out_valid stays 1.
  - Else: ptr <= sel+1 (wraps n_cell-1 -> 0) and burst_cnt <= 0.
    - Re-arbitrate using the current req from the new ptr.
    - If there is a winner: sel <= winner, out_valid stays 1, so back-to-back transfers have no bubble.
    - If there is none: out_valid <= 0, go to IDLE.
  - A sole remaining requester equal to the old sel is legally re-granted; it is found last in the search.
- Valid stability: once out_valid=1, neither sel nor out_valid changes until the handshake completes, even if req[sel] drops. The transfer completes and ack is still issued.
- Requester contract: hold req until ack. Data on mux input sel must be stable while out_valid=1.
- max_burst=1 gives pure round robin.
- Reset mid-transfer: the next rising edge with rst_n=0 returns to reset values. The pending word is dropped and no ack is issued.
- At most one ack bit high per cycle; ack is never high when out_valid=0.

Test Plan:
- rst_n=0 for 2 cycles with req=all ones, out_ready=1 -> sel=0, out_valid=0, ack=0 throughout; first cycle after release out_valid=1, sel=0.
- switch_bits=2, max_burst=1, req=4'b1111, out_ready=1 held -> sel sequence 0,1,2,3,0,1; ack 0001,0010,0100,1000,...; out_valid stays 1 with no bubble.
- req=4'b0100, out_ready=0 for 5 cycles -> sel=2, out_valid=1 stable, ack=0; out_ready=1 on cycle 6 -> ack=4'b0100 that cycle only; req dropped -> out_valid=0 next cycle.
- max_burst=3, switch_bits=2, req=4'b0011 held, out_ready=1 -> sel 0,0,0,1,1,1,0; burst limit and rotation correct.
- Wrap/sparse: grant on source 3 completes (ptr -> 0), req=4'b1001 -> next sel=0, then 3; req=4'b1000 alone after source 3 -> sel=3 re-granted.
- rst_n=0 asserted while out_valid=1, out_ready=0 -> next cycle out_valid=0, sel=0, ack never pulsed; req[sel] dropped mid-grant without reset -> out_valid held until out_ready, ack issued.
